spi_ram_arbiter: RTL and testbench
==================================

Name: spi_ram_arbiter

Overview:
- Sits between the SPI slave and a single-port synchronous RAM, and decodes the 10-bit SPI command words (2-bit opcode + 8-bit payload) into RAM accesses.
- Returns read data to the SPI slave through its tx_data/tx_valid interface.
- Shares the same RAM with a local host port through a one-access-at-a-time arbiter.

Parameters:
- ADDR_W, 8, RAM address width; must equal the SPI payload width.
- DATA_W, 8, RAM data width.
- TX_HOLD, 8, number of cycles tx_valid stays high per read (one per MISO bit).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_data  in  10  SPI word: [9:8] opcode, [7:0] payload
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  read data to SPI slave
- tx_valid  out  1  high TX_HOLD cycles per SPI read
- host_req  in  1  host access request; held until host_gnt
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  one-cycle pulse, host access issued
- host_rdata  out  DATA_W  host read data
- host_rvalid  out  1  one-cycle pulse, host_rdata valid
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_en
- spi_ovf  out  1  sticky: SPI word lost

Behaviour:
- Reset values: every output 0; wr_addr = 0, rd_addr = 0; pending slot empty; state ARB; TX counter 0. Reset mid-operation aborts immediately, including any in-flight read or TX window.
- Opcode decode on rx_valid:
  - 00: wr_addr <= payload; no RAM access.
  - 01: pend SPI write of payload to wr_addr.
  - 10: rd_addr <= payload; no RAM access.
  - 11: pend SPI read at rd_addr; payload ignored.
- Pending slot holds one entry. rx_valid with an op 01/11 while the slot is full overwrites the slot and sets spi_ovf; spi_ovf clears only on reset.
- All RAM outputs are registered. FSM states:
  - ARB: choose a requester from registered state and current inputs; the selected access drives ram_en high in the next cycle; go to ACC. Nothing eligible: stay in ARB.
  - ACC: ram_en = 1 for exactly this cycle. host_gnt pulses in this cycle for a host access. The pending slot clears in this cycle for an SPI access. Writes return to ARB; reads go to RDW.
  - RDW: capture ram_rdata at the end of this cycle; go to ARB.
- Read response timing: host_rvalid pulses, or tx_valid rises, in the cycle after RDW. Host read latency is ARB→response = 3 cycles.
- Eligibility:
  - An SPI read is eligible only when the TX counter = 0 (no TX window active).
  - An SPI write is always eligible.
  - The host is eligible whenever host_req = 1.
- Default arbitration: fixed priority, SPI over host.
- TX window:
  - On SPI read capture: tx_data <= ram_rdata, tx_valid = 1 for exactly TX_HOLD consecutive cycles, then 0.
  - tx_data is stable throughout the window.
  - Host accesses and SPI writes proceed during the window.
- Simultaneous rx_valid and grant of the old pending entry in ARB: the old entry is issued, the new entry fills the slot, no overflow.
- 00/10 opcodes update their address register immediately; a pending 01/11 uses the address value at grant time.
- No back-to-back accesses: at least one ARB cycle between ram_en pulses.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: round-robin. A one-bit last-winner register gives priority to the other requester on contention; it resets to "host", so SPI wins the first contention.
- Undefined: fixed SPI-over-host priority, and no last-winner register.

Test Plan:
- SPI write: rx 0x005 then 0x1A5 → one cycle with ram_en = 1, ram_we = 1, ram_addr = 0x05, ram_wdata = 0xA5.
- SPI read: RAM[0x05] = 0xA5; rx 0x205 then 0x300 → ram_en with ram_we = 0, ram_addr = 0x05; tx_data = 0xA5 with tx_valid high exactly 8 cycles.
- Host read of 0x10 holding 0x3C: host_req = 1, host_we = 0 → host_gnt pulse; host_rvalid with host_rdata = 0x3C 2 cycles later; 3 cycles after request in ARB.
- Contention: SPI write pending and host_req in the same ARB cycle → SPI granted first, host_gnt one access later. With ARB_ROUND_ROBIN_EN, a repeat contention grants host first.
- Overflow: two op-01 words before the first is granted (host occupying RAM) → spi_ovf = 1; only the second data value is written.
- Reset: rst_n low during the TX window → tx_valid = 0 and all outputs 0 asynchronously; after release, state ARB and pending slot empty.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// Decodes 10-bit SPI command words into RAM accesses and shares a single-port RAM with a host port.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed SPI-over-host priority.
module spi_ram_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W+1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              spi_ovf
);

  localparam int CNT_W = $clog2(TX_HOLD + 1);

  typedef enum logic [1:0] {
    ARB,
    ACC,
    RDW
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              pend_valid, pend_we;
  logic [DATA_W-1:0] pend_data;
  logic              acc_we, acc_host;
  logic [CNT_W-1:0]  tx_cnt;

  logic [1:0]        opcode;
  logic [ADDR_W-1:0] payload;
  logic              spi_elig, host_elig;
  logic              grant_spi, grant_host;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_spi;
`endif

  assign opcode  = rx_data[ADDR_W+1:ADDR_W];
  assign payload = rx_data[ADDR_W-1:0];

  // A pending SPI read waits until the previous TX window has fully drained.
  always_comb begin
    spi_elig   = pend_valid && (pend_we || (tx_cnt == '0));
    host_elig  = host_req;
    grant_spi  = 1'b0;
    grant_host = 1'b0;
    if (state == ARB) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (spi_elig && host_elig) begin
        grant_spi  = !last_spi;
        grant_host = last_spi;
      end else begin
        grant_spi  = spi_elig;
        grant_host = host_elig;
      end
`else
      grant_spi  = spi_elig;
      grant_host = host_elig && !spi_elig;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB:     if (grant_spi || grant_host) state_next = ACC;
      ACC:     state_next = acc_we ? ARB : RDW;
      RDW:     state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  // RAM request registers: loaded in ARB, so every strobe lasts exactly the ACC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      host_gnt  <= 1'b0;
      acc_we    <= 1'b0;
      acc_host  <= 1'b0;
    end else begin
      ram_en   <= grant_spi || grant_host;
      ram_we   <= 1'b0;
      host_gnt <= grant_host;
      if (grant_spi) begin
        ram_we    <= pend_we;
        ram_addr  <= pend_we ? wr_addr : rd_addr;
        ram_wdata <= pend_data;
        acc_we    <= pend_we;
        acc_host  <= 1'b0;
      end else if (grant_host) begin
        ram_we    <= host_we;
        ram_addr  <= host_addr;
        ram_wdata <= host_wdata;
        acc_we    <= host_we;
        acc_host  <= 1'b1;
      end
    end
  end

  // A new word arriving while the old one is being granted refills the slot without overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr    <= '0;
      rd_addr    <= '0;
      pend_valid <= 1'b0;
      pend_we    <= 1'b0;
      pend_data  <= '0;
      spi_ovf    <= 1'b0;
    end else begin
      if (rx_valid && opcode == 2'b00) wr_addr <= payload;
      if (rx_valid && opcode == 2'b10) rd_addr <= payload;
      if (rx_valid && opcode[0]) begin
        pend_valid <= 1'b1;
        pend_we    <= !opcode[1];
        pend_data  <= DATA_W'(payload);
        if (pend_valid && !grant_spi) spi_ovf <= 1'b1;
      end else if (grant_spi) begin
        pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      tx_cnt      <= '0;
    end else begin
      host_rvalid <= 1'b0;
      if (state == RDW && acc_host) begin
        host_rdata  <= ram_rdata;
        host_rvalid <= 1'b1;
      end
      if (state == RDW && !acc_host) begin
        tx_data  <= ram_rdata;
        tx_valid <= 1'b1;
        tx_cnt   <= CNT_W'(TX_HOLD);
      end else if (tx_cnt != '0) begin
        tx_cnt   <= tx_cnt - CNT_W'(1);
        tx_valid <= (tx_cnt != CNT_W'(1));
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Only contended grants move the last-winner pointer; it starts at "host".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_spi <= 1'b0;
    end else if (grant_spi && host_elig) begin
      last_spi <= 1'b1;
    end else if (grant_host && spi_elig) begin
      last_spi <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed self-checking bench for spi_ram_arbiter with a behavioural single-port RAM.
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdata;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata;
  logic [7:0] ram_rdata;
  logic       spi_ovf;

  logic [7:0] mem [0:255];
  int total = 0;
  int passed = 0;

  spi_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .TX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .spi_ovf(spi_ovf)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running, required finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic send_rx(input logic [9:0] w);
    rx_data  = w;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [47:0] outs;
    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    ram_rdata = '0;
    repeat (2) @(negedge clk);
    outs = {tx_data, tx_valid, host_gnt, host_rdata, host_rvalid, ram_en, ram_we, ram_addr, ram_wdata, spi_ovf, 7'd0};
    total++;
    if (outs !== 48'h0) $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
    else passed++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (ram_en !== 1'b0) $display("[TB] FAIL reset_idle_ram_en: got %b expected 0", ram_en);
    else passed++;
  endtask

  task automatic test_spi_write();
    send_rx(10'h005);
    send_rx(10'h1A5);
    total++;
    if (ram_en !== 1'b0) $display("[TB] FAIL wr_grant_cycle_en: got %b expected 0", ram_en);
    else passed++;
    @(negedge clk);
    total++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 8'h05, 8'hA5})
      $display("[TB] FAIL spi_write_access: got en=%b we=%b addr=%h wdata=%h expected en=1 we=1 addr=05 wdata=A5",
               ram_en, ram_we, ram_addr, ram_wdata);
    else passed++;
    @(negedge clk);
    total++;
    if (ram_en !== 1'b0) $display("[TB] FAIL spi_write_single_strobe: got %b expected 0", ram_en);
    else passed++;
    total++;
    if (mem[5] !== 8'hA5) $display("[TB] FAIL spi_write_mem: got %h expected a5", mem[5]);
    else passed++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_spi_read();
    int cnt, hold, bad;
    send_rx(10'h205);
    send_rx(10'h300);
    @(negedge clk);
    total++;
    if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 8'h05})
      $display("[TB] FAIL spi_read_access: got en=%b we=%b addr=%h expected en=1 we=0 addr=05", ram_en, ram_we, ram_addr);
    else passed++;
    cnt = 0;
    while (!tx_valid && cnt < 20) begin @(negedge clk); cnt++; end
    total++;
    if (cnt != 2) $display("[TB] FAIL spi_read_latency: got %0d expected 2", cnt);
    else passed++;
    hold = 0; bad = 0;
    while (tx_valid && hold < 20) begin
      if (tx_data !== 8'hA5) bad++;
      hold++;
      @(negedge clk);
    end
    total++;
    if (hold != 8) $display("[TB] FAIL tx_window_len: got %0d expected 8", hold);
    else passed++;
    total++;
    if (bad != 0) $display("[TB] FAIL tx_data_stable: got %0d bad cycles expected 0 (want a5)", bad);
    else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_host_read();
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h3C;
    @(negedge clk);
    total++;
    if ({host_gnt, ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 1'b1, 8'h10, 8'h3C})
      $display("[TB] FAIL host_write: got gnt=%b en=%b we=%b addr=%h wdata=%h expected 1 1 1 10 3c",
               host_gnt, ram_en, ram_we, ram_addr, ram_wdata);
    else passed++;
    host_req = 1'b0; host_we = 1'b0;
    @(negedge clk);
    host_req = 1'b1; host_addr = 8'h10;
    @(negedge clk);
    total++;
    if ({host_gnt, ram_en, ram_we, ram_addr} !== {1'b1, 1'b1, 1'b0, 8'h10})
      $display("[TB] FAIL host_read_gnt: got gnt=%b en=%b we=%b addr=%h expected 1 1 0 10", host_gnt, ram_en, ram_we, ram_addr);
    else passed++;
    host_req = 1'b0;
    @(negedge clk);
    total++;
    if (host_rvalid !== 1'b0) $display("[TB] FAIL host_rvalid_early: got %b expected 0", host_rvalid);
    else passed++;
    @(negedge clk);
    total++;
    if ({host_rvalid, host_rdata} !== {1'b1, 8'h3C})
      $display("[TB] FAIL host_read_data: got rvalid=%b rdata=%h expected 1 3c", host_rvalid, host_rdata);
    else passed++;
    @(negedge clk);
    total++;
    if (host_rvalid !== 1'b0) $display("[TB] FAIL host_rvalid_pulse: got %b expected 0", host_rvalid);
    else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_contention();
    send_rx(10'h022);
    send_rx(10'h155);
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'h77;
    @(negedge clk);
    total++;
    if ({ram_en, host_gnt, ram_addr, ram_wdata} !== {1'b1, 1'b0, 8'h22, 8'h55})
      $display("[TB] FAIL contention1_first: got en=%b gnt=%b addr=%h wdata=%h expected 1 0 22 55", ram_en, host_gnt, ram_addr, ram_wdata);
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if ({ram_en, host_gnt, ram_addr, ram_wdata} !== {1'b1, 1'b1, 8'h30, 8'h77})
      $display("[TB] FAIL contention1_second: got en=%b gnt=%b addr=%h wdata=%h expected 1 1 30 77", ram_en, host_gnt, ram_addr, ram_wdata);
    else passed++;
    host_req = 1'b0;
    repeat (2) @(negedge clk);
    send_rx(10'h166);
    host_req = 1'b1; host_addr = 8'h31; host_wdata = 8'h88;
    @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
    total++;
    if ({ram_en, host_gnt, ram_addr, ram_wdata} !== {1'b1, 1'b1, 8'h31, 8'h88})
      $display("[TB] FAIL contention2_first: got en=%b gnt=%b addr=%h wdata=%h expected 1 1 31 88", ram_en, host_gnt, ram_addr, ram_wdata);
    else passed++;
    host_req = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({ram_en, host_gnt, ram_addr, ram_wdata} !== {1'b1, 1'b0, 8'h22, 8'h66})
      $display("[TB] FAIL contention2_second: got en=%b gnt=%b addr=%h wdata=%h expected 1 0 22 66", ram_en, host_gnt, ram_addr, ram_wdata);
    else passed++;
`else
    total++;
    if ({ram_en, host_gnt, ram_addr, ram_wdata} !== {1'b1, 1'b0, 8'h22, 8'h66})
      $display("[TB] FAIL contention2_first: got en=%b gnt=%b addr=%h wdata=%h expected 1 0 22 66", ram_en, host_gnt, ram_addr, ram_wdata);
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if ({ram_en, host_gnt, ram_addr, ram_wdata} !== {1'b1, 1'b1, 8'h31, 8'h88})
      $display("[TB] FAIL contention2_second: got en=%b gnt=%b addr=%h wdata=%h expected 1 1 31 88", ram_en, host_gnt, ram_addr, ram_wdata);
    else passed++;
    host_req = 1'b0;
`endif
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overflow();
    int strobes;
    total++;
    if (spi_ovf !== 1'b0) $display("[TB] FAIL ovf_clear_before: got %b expected 0", spi_ovf);
    else passed++;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    @(negedge clk);
    host_req = 1'b0;
    rx_data = 10'h1AA; rx_valid = 1'b1;
    @(negedge clk);
    rx_data = 10'h1BB;
    @(negedge clk);
    rx_valid = 1'b0;
    total++;
    if (spi_ovf !== 1'b1) $display("[TB] FAIL ovf_set: got %b expected 1", spi_ovf);
    else passed++;
    @(negedge clk);
    total++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 8'h22, 8'hBB})
      $display("[TB] FAIL ovf_write: got en=%b we=%b addr=%h wdata=%h expected 1 1 22 bb", ram_en, ram_we, ram_addr, ram_wdata);
    else passed++;
    strobes = 0;
    repeat (8) begin @(negedge clk); if (ram_en) strobes++; end
    total++;
    if (strobes != 0) $display("[TB] FAIL ovf_single_write: got %0d extra strobes expected 0", strobes);
    else passed++;
    total++;
    if (mem[8'h22] !== 8'hBB) $display("[TB] FAIL ovf_mem: got %h expected bb", mem[8'h22]);
    else passed++;
  endtask

  task automatic test_reset_mid_tx();
    int cnt, strobes;
    logic [47:0] outs;
    send_rx(10'h300);
    cnt = 0;
    while (!tx_valid && cnt < 20) begin @(negedge clk); cnt++; end
    total++;
    if (tx_valid !== 1'b1) $display("[TB] FAIL mid_tx_window_open: got %b expected 1", tx_valid);
    else passed++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    outs = {tx_data, tx_valid, host_gnt, host_rdata, host_rvalid, ram_en, ram_we, ram_addr, ram_wdata, spi_ovf, 7'd0};
    total++;
    if (outs !== 48'h0) $display("[TB] FAIL async_reset_outputs: got %h expected 0", outs);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    strobes = 0;
    repeat (4) begin @(negedge clk); if (ram_en || tx_valid) strobes++; end
    total++;
    if (strobes != 0) $display("[TB] FAIL post_reset_quiet: got %0d active cycles expected 0", strobes);
    else passed++;
    send_rx(10'h1C3);
    @(negedge clk);
    total++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 8'h00, 8'hC3})
      $display("[TB] FAIL post_reset_write: got en=%b we=%b addr=%h wdata=%h expected 1 1 00 c3", ram_en, ram_we, ram_addr, ram_wdata);
    else passed++;
    repeat (2) @(negedge clk);
    send_rx(10'h300);
    cnt = 0;
    while (!tx_valid && cnt < 20) begin @(negedge clk); cnt++; end
    total++;
    if ({tx_valid, tx_data} !== {1'b1, 8'hC3})
      $display("[TB] FAIL post_reset_read: got valid=%b data=%h expected 1 c3", tx_valid, tx_data);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_spi_write();
    test_spi_read();
    test_host_read();
    test_contention();
    test_overflow();
    test_reset_mid_tx();
    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
